// File: rtl/pong_pkg.sv
// Shared scene geometry, colour codes and position/velocity types for the pong graphics blocks.
package pong_pkg;

  // Default scene geometry; blocks expose these as overridable parameters.
  localparam int DEF_H_RES      = 640;
  localparam int DEF_V_RES      = 480;
  localparam int DEF_WALL_X_L   = 32;
  localparam int DEF_WALL_X_R   = 35;
  localparam int DEF_BAR_X_L    = 600;
  localparam int DEF_BAR_X_R    = 603;
  localparam int DEF_BAR_Y_SIZE = 72;
  localparam int DEF_BAR_V      = 4;
  localparam int DEF_BALL_SIZE  = 8;
  localparam int DEF_BALL_V     = 2;

  localparam int POS_W = 10;
  localparam int VEL_W = 10;

  typedef logic [POS_W-1:0]        pos_t;
  typedef logic signed [VEL_W-1:0] vel_t;
  typedef logic [2:0]              rgb_t;

  localparam rgb_t COL_WALL  = 3'b001;
  localparam rgb_t COL_BAR   = 3'b010;
  localparam rgb_t COL_BALL  = 3'b100;
  localparam rgb_t COL_BG    = 3'b110;
  localparam rgb_t COL_BLANK = 3'b000;

  typedef struct packed {
    pos_t x;
    pos_t y;
    vel_t dx;
    vel_t dy;
  } ball_t;

endpackage

// File: rtl/pong_ref_tick.sv
// Frame refresh tick: one-cycle pulse on the rising edge of the scan reaching
// (pix_y == V_RES, pix_x == 0), suppressed while paused.
module pong_ref_tick
  import pong_pkg::*;
#(
  parameter int V_RES = DEF_V_RES
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [POS_W-1:0] pix_x_i,
  input  logic [POS_W-1:0] pix_y_i,
  input  logic             pause_i,
  output logic             ref_tick_o
);

  logic frame_start;
  logic frame_start_q;

  assign frame_start = (pix_y_i == POS_W'(V_RES)) && (pix_x_i == '0);

  // Resets high so a reset released while the scan sits on the frame-start
  // position waits for a fresh rising edge instead of ticking at once.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) frame_start_q <= 1'b1;
    else          frame_start_q <= frame_start;
  end

  assign ref_tick_o = frame_start && !frame_start_q && !pause_i;

endmodule

// File: rtl/pong_graph_anim.sv
// Animated pong scene: button-driven paddle, bouncing ball, hit/miss pulses and
// registered pixel colour for the VGA pipeline.
module pong_graph_anim
  import pong_pkg::*;
#(
  parameter int H_RES      = DEF_H_RES,
  parameter int V_RES      = DEF_V_RES,
  parameter int WALL_X_L   = DEF_WALL_X_L,
  parameter int WALL_X_R   = DEF_WALL_X_R,
  parameter int BAR_X_L    = DEF_BAR_X_L,
  parameter int BAR_X_R    = DEF_BAR_X_R,
  parameter int BAR_Y_SIZE = DEF_BAR_Y_SIZE,
  parameter int BAR_V      = DEF_BAR_V,
  parameter int BALL_SIZE  = DEF_BALL_SIZE,
  parameter int BALL_V     = DEF_BALL_V
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       video_on,
  input  logic [9:0] pix_x,
  input  logic [9:0] pix_y,
  input  logic [1:0] btn,
  input  logic       pause,
  output logic [2:0] graph_rgb,
  output logic       hit,
  output logic       miss
);

  localparam pos_t WALL_L     = pos_t'(WALL_X_L);
  localparam pos_t WALL_R     = pos_t'(WALL_X_R);
  localparam pos_t BAR_L      = pos_t'(BAR_X_L);
  localparam pos_t BAR_R      = pos_t'(BAR_X_R);
  localparam pos_t BAR_SPAN   = pos_t'(BAR_Y_SIZE - 1);
  localparam pos_t BAR_STEP   = pos_t'(BAR_V);
  localparam pos_t BAR_LIMIT  = pos_t'(V_RES - 1 - BAR_V);
  localparam pos_t BAR_Y_RST  = pos_t'((V_RES - BAR_Y_SIZE) / 2);
  localparam pos_t BALL_SPAN  = pos_t'(BALL_SIZE - 1);
  localparam pos_t BALL_X_RST = pos_t'(H_RES / 2);
  localparam pos_t BALL_Y_RST = pos_t'(V_RES / 2);
  localparam pos_t Y_BOTTOM   = pos_t'(V_RES - 1);
  localparam vel_t V_POS      = vel_t'(BALL_V);
  localparam vel_t V_NEG      = -vel_t'(BALL_V);

  logic  ref_tick;
  pos_t  bar_y_q, bar_y_d, bar_y_b;
  ball_t ball_q, ball_d;
  pos_t  ball_x_r, ball_y_b;
  logic  hit_q, hit_d, miss_q, miss_d;
  rgb_t  rgb_q, rgb_d;
  logic  wall_on, bar_on, ball_on, dx_pos;

  pong_ref_tick #(.V_RES(V_RES)) u_ref_tick (
    .clk       (clk),
    .reset_n   (reset_n),
    .pix_x_i   (pix_x),
    .pix_y_i   (pix_y),
    .pause_i   (pause),
    .ref_tick_o(ref_tick)
  );

  assign bar_y_b  = bar_y_q + BAR_SPAN;
  assign ball_x_r = ball_q.x + BALL_SPAN;
  assign ball_y_b = ball_q.y + BALL_SPAN;
  assign dx_pos   = !ball_q.dx[VEL_W-1] && (ball_q.dx != '0);

  // Collision tests use the pre-update paddle and ball; the add uses the old velocity.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    bar_y_d = bar_y_q;
    ball_d  = ball_q;
    hit_d   = 1'b0;
    miss_d  = 1'b0;
    if (ref_tick) begin
      if (btn == 2'b01 && bar_y_b < BAR_LIMIT)     bar_y_d = bar_y_q + BAR_STEP;
      else if (btn == 2'b10 && bar_y_q > BAR_STEP) bar_y_d = bar_y_q - BAR_STEP;

      ball_d.x = ball_q.x + pos_t'(ball_q.dx);
      ball_d.y = ball_q.y + pos_t'(ball_q.dy);

      if (ball_q.y <= pos_t'(1))     ball_d.dy = V_POS;
      else if (ball_y_b >= Y_BOTTOM) ball_d.dy = V_NEG;

      if (ball_x_r > BAR_R) begin
        ball_d.x  = BALL_X_RST;
        ball_d.y  = BALL_Y_RST;
        ball_d.dx = V_NEG;
        miss_d    = 1'b1;
      end else if (ball_x_r >= BAR_L && ball_y_b >= bar_y_q &&
                   ball_q.y <= bar_y_b && dx_pos) begin
        ball_d.dx = V_NEG;
        hit_d     = 1'b1;
      end else if (ball_q.x <= WALL_R) begin
        ball_d.dx = V_POS;
      end
    end
  end

  assign wall_on = (pix_x >= WALL_L) && (pix_x <= WALL_R);
  assign bar_on  = (pix_x >= BAR_L) && (pix_x <= BAR_R) &&
                   (pix_y >= bar_y_q) && (pix_y <= bar_y_b);
  assign ball_on = (pix_x >= ball_q.x) && (pix_x <= ball_x_r) &&
                   (pix_y >= ball_q.y) && (pix_y <= ball_y_b);

  always_comb begin
    rgb_d = COL_BG;
    if (!video_on)    rgb_d = COL_BLANK;
    else if (wall_on) rgb_d = COL_WALL;
    else if (bar_on)  rgb_d = COL_BAR;
    else if (ball_on) rgb_d = COL_BALL;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bar_y_q <= BAR_Y_RST;
      ball_q  <= '{x: BALL_X_RST, y: BALL_Y_RST, dx: V_NEG, dy: V_POS};
      hit_q   <= 1'b0;
      miss_q  <= 1'b0;
      rgb_q   <= COL_BLANK;
    end else begin
      bar_y_q <= bar_y_d;
      ball_q  <= ball_d;
      hit_q   <= hit_d;
      miss_q  <= miss_d;
      rgb_q   <= rgb_d;
    end
  end

  assign graph_rgb = rgb_q;
  assign hit       = hit_q;
  assign miss      = miss_q;

endmodule

// File: tb/tb_pong_graph_anim.sv
// Randomised self-checking bench for pong_graph_anim against a frame-level
// behavioural model of the paddle, ball and pixel colour rules.
module tb_pong_graph_anim;

  logic       clk = 1'b0, reset_n = 1'b0, video_on = 1'b0, pause = 1'b0;
  logic [9:0] pix_x = '0, pix_y = '0;
  logic [1:0] btn = '0;
  logic [2:0] graph_rgb;
  logic       hit, miss;

  int n_checks = 0, n_pass = 0, hits_seen = 0, misses_seen = 0;

  // Behavioural model state (plain integers, positions modulo 1024).
  int m_bar, m_bx, m_by, m_vx, m_vy, m_prev, m_hit, m_miss;
  logic [2:0] m_rgb;

  always #5 clk = ~clk;

  pong_graph_anim dut (
    .clk(clk), .reset_n(reset_n), .video_on(video_on), .pix_x(pix_x), .pix_y(pix_y),
    .btn(btn), .pause(pause), .graph_rgb(graph_rgb), .hit(hit), .miss(miss)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    m_bar = 204; m_bx = 320; m_by = 240; m_vx = -2; m_vy = 2;
    m_prev = 1; m_hit = 0; m_miss = 0; m_rgb = 3'b000;
  endtask

  function automatic logic [2:0] colour(input int x, input int y, input logic von);
    int bxr, byb;
    bxr = (m_bx + 7) % 1024;
    byb = (m_by + 7) % 1024;
    if (!von) return 3'b000;
    if (x >= 32 && x <= 35) return 3'b001;
    if (x >= 600 && x <= 603 && y >= m_bar && y <= m_bar + 71) return 3'b010;
    if (x >= m_bx && x <= bxr && y >= m_by && y <= byb) return 3'b100;
    return 3'b110;
  endfunction

  // One clock of the model: colour from current positions, then the frame update on a tick.
  task automatic model_step();
    int fs, tick, bxr, byb, nvx, nvy, nbx, nby;
    fs   = (int'(pix_y) == 480 && int'(pix_x) == 0);
    tick = fs && !m_prev && !pause;
    m_prev = fs;
    m_rgb  = colour(int'(pix_x), int'(pix_y), video_on);
    m_hit = 0; m_miss = 0;
    if (tick) begin
      bxr = (m_bx + 7) % 1024;
      byb = (m_by + 7) % 1024;
      nvx = m_vx; nvy = m_vy;
      nbx = (m_bx + m_vx + 1024) % 1024;
      nby = (m_by + m_vy + 1024) % 1024;
      if (m_by <= 1) nvy = 2;
      else if (byb >= 479) nvy = -2;
      if (bxr > 603) begin
        nbx = 320; nby = 240; nvx = -2; m_miss = 1;
      end else if (bxr >= 600 && bxr <= 603 && byb >= m_bar && m_by <= m_bar + 71 && m_vx > 0) begin
        nvx = -2; m_hit = 1;
      end else if (m_bx <= 35) begin
        nvx = 2;
      end
      if (btn == 2'b01 && m_bar + 71 < 475) m_bar = m_bar + 4;
      else if (btn == 2'b10 && m_bar > 4)   m_bar = m_bar - 4;
      m_bx = nbx; m_by = nby; m_vx = nvx; m_vy = nvy;
    end
  endtask

  task automatic check_state();
    check("bar_y", dut.bar_y_q, m_bar);
    check("ball_x", dut.ball_q.x, m_bx);
    check("ball_y", dut.ball_q.y, m_by);
    check("ball_dx", {22'b0, dut.ball_q.dx}, m_vx & 32'h3FF);
    check("ball_dy", {22'b0, dut.ball_q.dy}, m_vy & 32'h3FF);
  endtask

  // Inputs are driven at the negedge; outputs are checked at the following negedge.
  task automatic step_and_check();
    model_step();
    @(posedge clk);
    @(negedge clk);
    check("rgb", graph_rgb, m_rgb);
    check("hit", hit, m_hit);
    check("miss", miss, m_miss);
    check_state();
    hits_seen   += int'(hit);
    misses_seen += int'(miss);
  endtask

  function automatic int clampi(input int v, input int lo, input int hi);
    return (v < lo) ? lo : (v > hi) ? hi : v;
  endfunction

  task automatic frame(input logic [1:0] b, input logic p, input int probes);
    int sel;
    btn = b; pause = p;
    pix_x = 10'd0; pix_y = 10'd480; video_on = 1'b0;
    repeat ($urandom_range(1, 3)) step_and_check();
    repeat (probes) begin
      sel = $urandom_range(0, 3);
      case (sel)
        0: begin pix_x = 10'($urandom_range(0, 639)); pix_y = 10'($urandom_range(0, 479)); end
        1: begin
          pix_x = 10'(clampi(m_bx + $urandom_range(0, 11) - 2, 0, 639));
          pix_y = 10'(clampi(m_by + $urandom_range(0, 11) - 2, 0, 479));
        end
        2: begin
          pix_x = 10'($urandom_range(598, 605));
          pix_y = 10'(clampi(m_bar + $urandom_range(0, 78) - 3, 0, 479));
        end
        default: begin pix_x = 10'($urandom_range(30, 37)); pix_y = 10'($urandom_range(0, 479)); end
      endcase
      video_on = ($urandom_range(0, 7) != 0);
      step_and_check();
    end
  endtask

  function automatic logic [1:0] chase_btn();
    int ball_c, bar_c;
    ball_c = m_by + 4;
    bar_c  = m_bar + 36;
    if (ball_c < bar_c - 2) return 2'b10;
    if (ball_c > bar_c + 2) return 2'b01;
    return 2'b00;
  endfunction

  initial begin
    int s_bar, s_bx, s_by, h0, m0, n;
    logic [1:0] b;
    model_reset();

    // Reset held mid-frame, then released.
    pix_x = 10'd100; pix_y = 10'd200; video_on = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_bar_y", dut.bar_y_q, 204);
    check("rst_ball_x", dut.ball_q.x, 320);
    check("rst_ball_y", dut.ball_q.y, 240);
    check("rst_rgb", graph_rgb, 3'b000);
    check("rst_hit", hit, 1'b0);
    check("rst_miss", miss, 1'b0);
    reset_n = 1'b1;
    pix_x = 10'd33; pix_y = 10'd100; video_on = 1'b1;
    step_and_check();
    check("rst_wall_px", graph_rgb, 3'b001);

    // Paddle clamps at both ends; both buttons together hold it.
    repeat (60) frame(2'b10, 1'b0, 2);
    check("clamp_top", dut.bar_y_q, 4);
    repeat (5) frame(2'b11, 1'b0, 2);
    check("hold_btn11", dut.bar_y_q, 4);
    repeat (110) frame(2'b01, 1'b0, 2);
    check("clamp_bottom", dut.bar_y_q, 404);

    // Pause freezes motion and suppresses pulses while colour keeps flowing.
    s_bar = m_bar; s_bx = m_bx; s_by = m_by; h0 = hits_seen; m0 = misses_seen;
    repeat (10) frame(2'($urandom_range(0, 3)), 1'b1, 3);
    check("pause_bar", dut.bar_y_q, s_bar);
    check("pause_ball_x", dut.ball_q.x, s_bx);
    check("pause_ball_y", dut.ball_q.y, s_by);
    check("pause_pulses", hits_seen + misses_seen - h0 - m0, 0);

    // Randomised play: chase phases produce hits, random phases produce misses.
    for (int f = 0; f < 2400; f++) begin
      if (((f / 400) % 3) == 1 || $urandom_range(0, 9) == 0) b = 2'($urandom_range(0, 3));
      else b = chase_btn();
      frame(b, ($urandom_range(0, 15) == 0), $urandom_range(2, 5));
    end

    // Asynchronous reset while the scan sits on the frame-start position.
    @(negedge clk);
    pix_x = 10'd0; pix_y = 10'd480; video_on = 1'b0; btn = 2'b01; pause = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_bar", dut.bar_y_q, 204);
    check("async_rst_x", dut.ball_q.x, 320);
    check("async_rst_y", dut.ball_q.y, 240);
    check("async_rst_rgb", graph_rgb, 3'b000);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) step_and_check();
    check("no_tick_after_rst", dut.ball_q.x, 320);

    // Paddle parked at the top until a miss shows up.
    m0 = misses_seen; n = 0;
    while (misses_seen == m0 && n < 2500) begin
      frame(2'b10, 1'b0, 3);
      n++;
    end
    check("miss_seen", (misses_seen > m0), 1);
    check("hit_seen", (hits_seen > 0), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
